mips_wb_stage: RTL and testbench
================================

Name: mips_wb_stage

Overview:
- MEM/WB pipeline stage of the MIPS CPU; sits directly upstream of the register file and drives its write port (wn, d, we).
- Aligns and extends load data.
- Arbitrates the single write port between the main pipeline and the multi-cycle mult/div unit; pipeline has priority.
- Keeps a pending-destination scoreboard so decode can stall on registers still owed by mult/div.

Parameters:
- DW, 32, datapath width
- RW, 5, register-number width

Ports:
- clk  in  1  clock
- clr  in  1  synchronous active-high reset
- m_valid  in  1  MEM stage holds a valid instruction
- m_wreg  in  1  instruction writes a register
- m_m2reg  in  1  result comes from memory (load)
- m_rn  in  5  destination register
- m_alu  in  32  ALU result
- m_mem  in  32  raw memory read word
- m_ld_type  in  3  0=LW 1=LH 2=LHU 3=LB 4=LBU; others reserved
- m_addr_lo  in  2  low address bits of load
- md_valid  in  1  mult/div result available
- md_rn  in  5  mult/div destination
- md_data  in  32  mult/div result
- md_ready  out  1  result accepted this cycle
- md_issue  in  1  decode issues a mult/div op
- md_issue_rn  in  5  its destination
- d_rs  in  5  decode source register rs
- d_rt  in  5  decode source register rt
- d_rd  in  5  decode destination register
- stall_req  out  1  decode must stall
- md_busy  out  1  any scoreboard bit set
- wn  out  5  regfile write register (also forwarding tag)
- d  out  32  regfile write data (also forwarding data)
- we  out  1  regfile write enable
- ld_err  out  1  one-cycle pulse on misaligned load

Behaviour:
- Reset (clr=1 at posedge): we=0, wn=0, d=0, ld_err=0, pending[31:0]=0. A reset mid-operation drops any in-flight write and clears the scoreboard. md_ready is combinational and is not gated by reset.
- p_wr = m_valid & m_wreg & (m_rn!=0) & !misalign.
- misalign = m_valid & m_m2reg & ((LW & m_addr_lo!=0) | ((LH|LHU) & m_addr_lo[0])).
- md_ready = md_valid & !p_wr (combinational). The mult/div unit holds md_* stable until md_ready.
- Each posedge, not in reset:
  - p_wr: we<=1, wn<=m_rn, d<=(m_m2reg ? aligned : m_alu).
  - else md_ready: we<=1, wn<=md_rn, d<=md_data.
  - else: we<=0; wn and d hold.
  - ld_err<=misalign. A misaligned load never writes.
- Load alignment is little-endian; byte k = m_mem[8k+7:8k].
  - LB/LBU: byte m_addr_lo, sign- or zero-extended.
  - LH/LHU: halfword m_addr_lo[1], sign- or zero-extended.
  - LW: full word.
  - Reserved m_ld_type behaves as LW.
- Latency: one cycle from MEM inputs to we/wn/d. The regfile commits on the following edge, so decode forwards from wn/d while we=1.
- Scoreboard:
  - md_issue & md_issue_rn!=0 sets pending[md_issue_rn].
  - md_ready clears pending[md_rn].
  - If set and clear hit the same register in one cycle, set wins.
  - pending[0] is always 0.
- stall_req = (d_rs!=0 & pending[d_rs]) | (d_rt!=0 & pending[d_rt]) | (d_rd!=0 & pending[d_rd]). This is combinational and also covers WAW.
- md_busy = |pending.
- Decode does not issue a mult/div op while md_busy=1; the bench asserts this.
- Writes to r0 never assert we. An md_rn=0 result is accepted (md_ready=1) and discarded with we=0.

Decomposition:
- Shared package mips_pkg:
  - load-type encodings LD_LW..LD_LBU
  - register-number width
  - R0 constant
- One natural sub-module: mips_load_align, combinational (m_mem, m_ld_type, m_addr_lo -> aligned data, misalign).
- Scoreboard and arbitration stay in the top.

Test Plan:
- Reset: clr=1 for 2 cycles with m_valid=1 -> we=0, wn=0, d=0, md_busy=0, ld_err=0; the first write appears only one cycle after clr falls.
- ALU write: m_rn=5, m_alu=0x1234_5678, m_m2reg=0 -> next cycle we=1, wn=5, d=0x1234_5678; m_rn=0 -> we=0.
- Loads with m_mem=0x80FF_7F01:
  - LB addr 3 -> 0xFFFF_FF80; LBU addr 1 -> 0x0000_007F.
  - LH addr 2 -> 0xFFFF_80FF; LHU addr 0 -> 0x0000_7F01.
  - LW addr 2 -> we=0, ld_err=1 for one cycle.
- Arbitration: md_valid=1, md_rn=9 while the pipeline writes r4 for 2 cycles -> md_ready=0 for both; the third cycle has no pipeline write -> md_ready=1, then we=1, wn=9, d=md_data.
- Scoreboard: md_issue_rn=9 -> md_busy=1, and d_rs=9 gives stall_req=1; after md result accept -> stall_req=0, md_busy=0. Same-cycle issue and retire of r9 -> pending[9] stays 1.
- Mid-operation reset: pending[9]=1 and md_valid held, clr=1 one cycle -> pending=0, we=0; no stall after reset.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: load-type encodings and register numbering.
package mips_pkg;

    // Register-number width and the hard-wired zero register.
    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] R0 = '0;

    // Load-type encodings carried from decode down to write-back.
    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LH  = 3'd1,
        LD_LHU = 3'd2,
        LD_LB  = 3'd3,
        LD_LBU = 3'd4
    } ld_type_e;

endpackage

// File: rtl/mips_load_align.sv
// Little-endian load alignment: picks the addressed byte/halfword, extends it,
// and flags accesses whose address is not naturally aligned for the access size.
module mips_load_align
    import mips_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic [DW-1:0] mem,
    input  logic [2:0]    ld_type,
    input  logic [1:0]    addr_lo,
    output logic [DW-1:0] aligned,
    output logic          misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select: byte k lives in mem[8k+7:8k].
    always_comb begin
        byte_sel = mem[7:0];
        unique case (addr_lo)
            2'd0: byte_sel = mem[7:0];
            2'd1: byte_sel = mem[15:8];
            2'd2: byte_sel = mem[23:16];
            2'd3: byte_sel = mem[31:24];
            default: byte_sel = mem[7:0];
        endcase
        half_sel = addr_lo[1] ? mem[31:16] : mem[15:0];
    end

    // Extension by load type; reserved encodings return the full word like LW.
    always_comb begin
        aligned = mem;
        case (ld_type)
            LD_LB:   aligned = {{(DW-8){byte_sel[7]}}, byte_sel};
            LD_LBU:  aligned = {{(DW-8){1'b0}}, byte_sel};
            LD_LH:   aligned = {{(DW-16){half_sel[15]}}, half_sel};
            LD_LHU:  aligned = {{(DW-16){1'b0}}, half_sel};
            default: aligned = mem;
        endcase
    end

    // Alignment fault detection; only the defined word/halfword types can fault.
    always_comb begin
        misalign = 1'b0;
        case (ld_type)
            LD_LW:          misalign = (addr_lo != 2'd0);
            LD_LH, LD_LHU:  misalign = addr_lo[0];
            default:        misalign = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_wb_stage.sv
// MEM/WB stage: drives the register-file write port, arbitrates it between the
// pipeline and the mult/div unit, and tracks registers still owed by mult/div.
module mips_wb_stage
    import mips_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = REG_W
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          m_valid,
    input  logic          m_wreg,
    input  logic          m_m2reg,
    input  logic [RW-1:0] m_rn,
    input  logic [DW-1:0] m_alu,
    input  logic [DW-1:0] m_mem,
    input  logic [2:0]    m_ld_type,
    input  logic [1:0]    m_addr_lo,
    input  logic          md_valid,
    input  logic [RW-1:0] md_rn,
    input  logic [DW-1:0] md_data,
    output logic          md_ready,
    input  logic          md_issue,
    input  logic [RW-1:0] md_issue_rn,
    input  logic [RW-1:0] d_rs,
    input  logic [RW-1:0] d_rt,
    input  logic [RW-1:0] d_rd,
    output logic          stall_req,
    output logic          md_busy,
    output logic [RW-1:0] wn,
    output logic [DW-1:0] d,
    output logic          we,
    output logic          ld_err
);

    localparam int unsigned NREG = 1 << RW;

    logic [DW-1:0]   aligned;
    logic            align_fault;
    logic            misalign;
    logic            p_wr;
    logic [NREG-1:0] pending_q, pending_d;

    mips_load_align #(
        .DW (DW)
    ) u_align (
        .mem      (m_mem),
        .ld_type  (m_ld_type),
        .addr_lo  (m_addr_lo),
        .aligned  (aligned),
        .misalign (align_fault)
    );

    // Port arbitration: pipeline first, mult/div only on a free cycle.
    always_comb begin
        misalign = m_valid & m_m2reg & align_fault;
        p_wr     = m_valid & m_wreg & (m_rn != R0[RW-1:0]) & ~misalign;
        md_ready = md_valid & ~p_wr;
    end

    // Scoreboard next state: retire clears, issue sets and wins on a collision.
    always_comb begin
        pending_d = pending_q;
        if (md_ready) begin
            pending_d[md_rn] = 1'b0;
        end
        if (md_issue && (md_issue_rn != R0[RW-1:0])) begin
            pending_d[md_issue_rn] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Decode hazard view of the scoreboard (RAW on rs/rt, WAW on rd).
    always_comb begin
        stall_req = ((d_rs != R0[RW-1:0]) & pending_q[d_rs]) |
                    ((d_rt != R0[RW-1:0]) & pending_q[d_rt]) |
                    ((d_rd != R0[RW-1:0]) & pending_q[d_rd]);
        md_busy   = |pending_q;
    end

    // Write-port register and scoreboard state; an r0 mult/div result is accepted but dropped.
    always_ff @(posedge clk) begin
        if (clr) begin
            we        <= 1'b0;
            wn        <= '0;
            d         <= '0;
            ld_err    <= 1'b0;
            pending_q <= '0;
        end else begin
            ld_err    <= misalign;
            pending_q <= pending_d;
            if (p_wr) begin
                we <= 1'b1;
                wn <= m_rn;
                d  <= m_m2reg ? aligned : m_alu;
            end else if (md_ready && (md_rn != R0[RW-1:0])) begin
                we <= 1'b1;
                wn <= md_rn;
                d  <= md_data;
            end else begin
                we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mips_wb_stage.sv
// Scoreboard bench for mips_wb_stage: the driver queues each expected write-port
// event; a monitor pops and compares whenever we or ld_err is raised.
module tb_mips_wb_stage;

    typedef struct packed {
        logic        we;
        logic [4:0]  wn;
        logic [31:0] d;
        logic        ld_err;
    } ev_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        m_valid, m_wreg, m_m2reg;
    logic [4:0]  m_rn;
    logic [31:0] m_alu, m_mem;
    logic [2:0]  m_ld_type;
    logic [1:0]  m_addr_lo;
    logic        md_valid;
    logic [4:0]  md_rn;
    logic [31:0] md_data;
    logic        md_ready;
    logic        md_issue;
    logic [4:0]  md_issue_rn;
    logic [4:0]  d_rs, d_rt, d_rd;
    logic        stall_req, md_busy;
    logic [4:0]  wn;
    logic [31:0] d;
    logic        we, ld_err;

    int errors = 0;
    int checks = 0;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    mips_wb_stage dut (
        .clk         (clk),
        .clr         (clr),
        .m_valid     (m_valid),
        .m_wreg      (m_wreg),
        .m_m2reg     (m_m2reg),
        .m_rn        (m_rn),
        .m_alu       (m_alu),
        .m_mem       (m_mem),
        .m_ld_type   (m_ld_type),
        .m_addr_lo   (m_addr_lo),
        .md_valid    (md_valid),
        .md_rn       (md_rn),
        .md_data     (md_data),
        .md_ready    (md_ready),
        .md_issue    (md_issue),
        .md_issue_rn (md_issue_rn),
        .d_rs        (d_rs),
        .d_rt        (d_rt),
        .d_rd        (d_rd),
        .stall_req   (stall_req),
        .md_busy     (md_busy),
        .wn          (wn),
        .d           (d),
        .we          (we),
        .ld_err      (ld_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    task automatic push(input logic w, input logic [4:0] n, input logic [31:0] v, input logic e);
        ev_t ev;
        ev.we = w; ev.wn = n; ev.d = v; ev.ld_err = e;
        exp_q.push_back(ev);
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] t, input logic [1:0] a);
        m_valid = 1'b1; m_wreg = 1'b1; m_m2reg = 1'b1; m_rn = 5'd6;
        m_ld_type = t; m_addr_lo = a;
    endtask

    // Monitor: compare every presented write/err event against the queue head.
    always @(negedge clk) begin
        if (we === 1'b1 || ld_err === 1'b1) begin
            ev_t ex;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got we=%0b wn=%0d d=%08h ld_err=%0b, none expected",
                         we, wn, d, ld_err);
            end else begin
                ex = exp_q.pop_front();
                if ({we, wn, d, ld_err} !== ex) begin
                    errors++;
                    $display("FAIL wb_event: got we=%0b wn=%0d d=%08h ld_err=%0b expected we=%0b wn=%0d d=%08h ld_err=%0b",
                             we, wn, d, ld_err, ex.we, ex.wn, ex.d, ex.ld_err);
                end
            end
        end
    end

    // Decode must not issue while mult/div work is outstanding.
    always @(posedge clk) begin
        if (md_issue === 1'b1 && clr === 1'b0) begin
            checks++;
            if (md_busy !== 1'b0) begin
                errors++;
                $display("FAIL issue_while_busy: got md_busy=%0b expected 0", md_busy);
            end
        end
    end

    initial begin
        clr = 1'b1;
        m_valid = 1'b1; m_wreg = 1'b1; m_m2reg = 1'b0; m_rn = 5'd5;
        m_alu = 32'h1234_5678; m_mem = 32'h80FF_7F01; m_ld_type = 3'd0; m_addr_lo = 2'd0;
        md_valid = 1'b0; md_rn = 5'd0; md_data = 32'h0;
        md_issue = 1'b0; md_issue_rn = 5'd0;
        d_rs = 5'd0; d_rt = 5'd0; d_rd = 5'd0;

        // Reset held two cycles with a valid write on the inputs.
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("rst_we", {31'b0, we}, 32'h0);
            chk("rst_wn", {27'b0, wn}, 32'h0);
            chk("rst_d", d, 32'h0);
            chk("rst_ld_err", {31'b0, ld_err}, 32'h0);
            chk("rst_md_busy", {31'b0, md_busy}, 32'h0);
        end

        // First write lands one edge after clr falls.
        clr = 1'b0;
        push(1'b1, 5'd5, 32'h1234_5678, 1'b0);
        cyc();
        m_rn = 5'd0;
        cyc();
        chk("r0_no_we", {31'b0, we}, 32'h0);

        // Loads from 0x80FF_7F01.
        load(3'd3, 2'd3); push(1'b1, 5'd6, 32'hFFFF_FF80, 1'b0); cyc();
        load(3'd4, 2'd1); push(1'b1, 5'd6, 32'h0000_007F, 1'b0); cyc();
        load(3'd1, 2'd2); push(1'b1, 5'd6, 32'hFFFF_80FF, 1'b0); cyc();
        load(3'd7, 2'd0); push(1'b1, 5'd6, 32'h80FF_7F01, 1'b0); cyc();
        load(3'd2, 2'd0); push(1'b1, 5'd6, 32'h0000_7F01, 1'b0); cyc();
        // Misaligned LW: no write, wn/d hold, one-cycle error.
        load(3'd0, 2'd2); push(1'b0, 5'd6, 32'h0000_7F01, 1'b1); cyc();
        m_valid = 1'b0;
        cyc();
        chk("ld_err_pulse", {31'b0, ld_err}, 32'h0);

        // Scoreboard: issue r9, decode reading r9 stalls.
        md_issue = 1'b1; md_issue_rn = 5'd9;
        cyc();
        md_issue = 1'b0;
        d_rs = 5'd9;
        #1;
        chk("busy_after_issue", {31'b0, md_busy}, 32'h1);
        chk("stall_rs", {31'b0, stall_req}, 32'h1);

        // Arbitration: pipeline writes r4 for two cycles while r9 result waits.
        m_valid = 1'b1; m_wreg = 1'b1; m_m2reg = 1'b0; m_rn = 5'd4; m_alu = 32'h0000_000A;
        md_valid = 1'b1; md_rn = 5'd9; md_data = 32'hDEAD_BEEF;
        #1;
        chk("md_ready_blocked1", {31'b0, md_ready}, 32'h0);
        push(1'b1, 5'd4, 32'h0000_000A, 1'b0);
        cyc();
        m_alu = 32'h0000_000B;
        #1;
        chk("md_ready_blocked2", {31'b0, md_ready}, 32'h0);
        push(1'b1, 5'd4, 32'h0000_000B, 1'b0);
        cyc();
        m_valid = 1'b0;
        #1;
        chk("md_ready_free", {31'b0, md_ready}, 32'h1);
        push(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0);
        cyc();
        md_valid = 1'b0;
        #1;
        chk("stall_cleared", {31'b0, stall_req}, 32'h0);
        chk("busy_cleared", {31'b0, md_busy}, 32'h0);

        // Same-cycle retire and issue of r9: the set wins.
        md_valid = 1'b1; md_rn = 5'd9; md_data = 32'h0000_1111;
        md_issue = 1'b1; md_issue_rn = 5'd9;
        push(1'b1, 5'd9, 32'h0000_1111, 1'b0);
        cyc();
        md_issue = 1'b0;
        md_data = 32'h0000_0005;
        d_rs = 5'd0; d_rd = 5'd9;
        #1;
        chk("set_wins_busy", {31'b0, md_busy}, 32'h1);
        chk("stall_waw_rd", {31'b0, stall_req}, 32'h1);

        // Mid-operation reset with the result still offered.
        clr = 1'b1;
        cyc();
        chk("midrst_we", {31'b0, we}, 32'h0);
        chk("midrst_busy", {31'b0, md_busy}, 32'h0);
        clr = 1'b0; md_valid = 1'b0;
        d_rs = 5'd9; d_rt = 5'd9; d_rd = 5'd9;
        #1;
        chk("midrst_no_stall", {31'b0, stall_req}, 32'h0);
        cyc();

        // Drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc();
        chk("queue_drained", exp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
